rtc_write_seq: RTL
==================

RTC_WRITE_SEQ -- requirements
Module: rtc_write_seq

Interface
REQ-001 Parameter T_PH, default 8: cycles per bus phase; legal range 2..255.
REQ-002 Parameter CMD_DATA, default 8'h00: data byte written in the command transfer.
REQ-003 Clock and reset are decided: reset reset, asynchronous, active-high; clock clk.
REQ-004 clk  in  1  system clock; all outputs change on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high; forces the idle state.
REQ-006 start  in  1  one-cycle request to begin a write sequence.
REQ-007 wr_mask  in  9  per-register enable; bit 0 = seconds ... bit 8 = timer hours (order in REQ-012).
REQ-008 reg_data  in  8  data byte for the register currently selected by reg_idx.
REQ-009 reg_idx  out  4  index of the current transfer: 0 = command, 1..9 = registers.
REQ-010 ad_out  out  8  value driven onto the multiplexed RTC address/data bus.
REQ-011 ad_oe  out  1  bus drive enable; a_d, cs, rd, wr  out  1 each; busy  out  1; done  out  1.

Function
REQ-012 Transfer table, held in the package, as index:address:
- 0:F1 command
- 1:21 seconds
- 2:22 minutes
- 3:23 hours
- 4:24 day
- 5:25 month
- 6:26 year
- 7:41 timer seconds
- 8:42 timer minutes
- 9:43 timer hours
REQ-013 The FSM states are IDLE, ADR_STB, ADR_REL, DAT_STB, DAT_REL, NEXT and DONE; each of the four bus states lasts exactly T_PH cycles, counted by an 8-bit phase counter.
REQ-014 IDLE: when start=1, the FSM sets reg_idx=0 and busy=1 and enters ADR_STB on the next edge.
REQ-015 start is ignored while busy=1; no queuing.
REQ-016 ADR_STB: ad_out=table address, ad_oe=1, a_d=0, cs=0, wr=0, rd=1.
REQ-017 ADR_REL and DAT_REL: cs=1, wr=1, rd=1 and ad_oe=1; ad_out holds the last value.
REQ-018 DAT_STB: a_d=1, cs=0, wr=0, rd=1, ad_oe=1, and ad_out=the latched data byte.
REQ-019 Data byte latch:
- captured on the edge entering DAT_STB
- CMD_DATA when reg_idx=0, else reg_data
- reg_data needs to be valid only in the cycle before DAT_STB.
REQ-020 NEXT (exactly 1 cycle) advances reg_idx to the next index whose wr_mask bit is set, skipping masked-off indices in that same cycle.
- If a set bit remains, the FSM goes to ADR_STB.
- If none remains, it goes to DONE.
REQ-021 wr_mask is sampled only at start; changes during a sequence have no effect.
REQ-022 wr_mask=0: only the command transfer occurs.
REQ-023 wr_mask=9'h1FF: all 10 transfers occur.
REQ-024 DONE lasts 1 cycle with done=1 and busy=1; the FSM then returns to IDLE with busy=0.
REQ-025 Per-transfer latency is 4*T_PH+1 cycles (includes NEXT).
REQ-026 Full sequence latency, from the start edge to done, is 1+N*(4*T_PH+1) cycles, where N = 1 + popcount(mask).
REQ-027 rd is 1 in every state; the block never reads the RTC.
REQ-028 cs=0 and wr=0 are asserted only in ADR_STB and DAT_STB; they are never asserted together with rd=0.
REQ-029 In IDLE and DONE: ad_oe=0, ad_out=0, cs=wr=rd=a_d=1.

Reset
REQ-030 On reset, every output goes to its idle value immediately, without waiting for a clock edge:
- ad_oe=0, ad_out=0
- a_d=cs=rd=wr=1
- busy=0, done=0, reg_idx=0
REQ-031 The state becomes IDLE, and the phase counter, latched mask and latched data clear.
REQ-032 Reset mid-transfer aborts the sequence with no completion of the strobe; done is not pulsed.

Structure
REQ-033 The shared package rtc_pkg holds:
- the address table (REQ-012)
- the FSM state type
- the index width and the constant NUM_REGS=9
REQ-034 The bus timing is one sub-module, rtc_bus_phase (phase counter plus strobe generation), instantiated once.
- Interface: phase_start, phase_sel(addr/data), phase_end.
- The sequencer FSM stays in rtc_write_seq.

Verification
REQ-035 Full sequence, T_PH=8, wr_mask=1FF, reg_data=8'h10+reg_idx:
- 10 address strobes, in order F1,21..26,41..43
- data bytes 00,11..19
- done exactly 331 cycles after the start edge.
REQ-036 wr_mask=0:
- one transfer only, F1/00
- done 34 cycles after start
- reg_idx never exceeds 0.
REQ-037 wr_mask=9'b100000001:
- transfers at index 0, 1 and 9 only
- address strobes F1, 21, 43
- done at 1+3*33=100 cycles.
REQ-038 start re-pulsed while busy, and wr_mask changed mid-sequence:
- the sequence and its timing are unchanged
- exactly one done pulse.
REQ-039 Reset asserted during the 3rd DAT_STB:
- outputs are at idle values in the same cycle
- no done pulse
- a new start afterwards begins again at index 0.
REQ-040 Protocol checker, over all tests:
- rd never 0
- cs=0 only in the two strobe states
- a_d is stable while cs=0
- ad_out is stable while cs=0
- each strobe is exactly T_PH cycles (also run with T_PH=2).

Source files
------------

// File: rtl/rtc_pkg.sv
// Shared types and constants for the RTC write sequencer: transfer table, FSM states and
// the index helper used to skip masked-off registers.
package rtc_pkg;

  localparam int unsigned NUM_REGS = 9;
  localparam int unsigned IDX_W    = 4;

  typedef enum logic [2:0] {
    StIdle,
    StAdrStb,
    StAdrRel,
    StDatStb,
    StDatRel,
    StNext,
    StDone
  } rtc_state_e;

  // Index 0 is the command transfer, 1..9 the clock and timer registers.
  function automatic logic [7:0] rtc_addr(input logic [IDX_W-1:0] idx);
    logic [7:0] addr;
    case (idx)
      4'd0:    addr = 8'hF1;
      4'd1:    addr = 8'h21;
      4'd2:    addr = 8'h22;
      4'd3:    addr = 8'h23;
      4'd4:    addr = 8'h24;
      4'd5:    addr = 8'h25;
      4'd6:    addr = 8'h26;
      4'd7:    addr = 8'h41;
      4'd8:    addr = 8'h42;
      4'd9:    addr = 8'h43;
      default: addr = 8'h00;
    endcase
    return addr;
  endfunction

  // Lowest enabled index above cur; 0 means nothing is left (0 is never a successor).
  function automatic logic [IDX_W-1:0] rtc_next_idx(input logic [NUM_REGS-1:0] mask,
                                                    input logic [IDX_W-1:0]    cur);
    logic [IDX_W-1:0] res;
    res = '0;
    for (int i = int'(NUM_REGS); i >= 1; i--) begin
      if (mask[i-1] && (i > int'(cur))) res = IDX_W'(i);
    end
    return res;
  endfunction

endpackage

// File: rtl/rtc_write_seq_if.sv
// Host-side request and RTC bus signals of the write sequencer.
interface rtc_write_seq_if;
  import rtc_pkg::*;

  logic                start;
  logic [NUM_REGS-1:0] wr_mask;
  logic [7:0]          reg_data;
  logic [IDX_W-1:0]    reg_idx;
  logic [7:0]          ad_out;
  logic                ad_oe;
  logic                a_d;
  logic                cs;
  logic                rd;
  logic                wr;
  logic                busy;
  logic                done;

  modport master (
    output start, wr_mask, reg_data,
    input  reg_idx, ad_out, ad_oe, a_d, cs, rd, wr, busy, done
  );

  modport slave (
    input  start, wr_mask, reg_data,
    output reg_idx, ad_out, ad_oe, a_d, cs, rd, wr, busy, done
  );

endinterface

// File: rtl/rtc_bus_phase.sv
// One bus phase: a T_PH-cycle strobe (cs/wr low) followed by a T_PH-cycle release.
// phase_end pulses in the last cycle of each half.
module rtc_bus_phase #(
  parameter int unsigned T_PH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic i_phase_start,
  input  logic i_phase_sel,
  output logic o_phase_end,
  output logic o_cs,
  output logic o_wr,
  output logic o_a_d
);

  localparam logic [7:0] LastCnt = 8'(T_PH - 1);

  typedef enum logic [1:0] {PhIdle, PhStb, PhRel} ph_e;

  ph_e        r_ph;
  logic [7:0] r_cnt;
  logic       r_cs;
  logic       r_wr;
  logic       r_a_d;

  assign o_phase_end = (r_ph != PhIdle) && (r_cnt == LastCnt);
  assign o_cs        = r_cs;
  assign o_wr        = r_wr;
  assign o_a_d       = r_a_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ph  <= PhIdle;
      r_cnt <= '0;
      r_cs  <= 1'b1;
      r_wr  <= 1'b1;
      r_a_d <= 1'b1;
    end else if (i_phase_start) begin
      r_ph  <= PhStb;
      r_cnt <= '0;
      r_cs  <= 1'b0;
      r_wr  <= 1'b0;
      r_a_d <= i_phase_sel;
    end else begin
      case (r_ph)
        PhStb: begin
          if (o_phase_end) begin
            r_ph  <= PhRel;
            r_cnt <= '0;
            r_cs  <= 1'b1;
            r_wr  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        PhRel: begin
          if (o_phase_end) begin
            r_ph  <= PhIdle;
            r_cnt <= '0;
            r_a_d <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: begin
          r_ph  <= PhIdle;
          r_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/rtc_write_seq.sv
// Writes the command byte and the wr_mask-selected clock/timer registers to the RTC over the
// multiplexed address/data bus; one address phase and one data phase per transfer.
module rtc_write_seq
  import rtc_pkg::*;
#(
  parameter int unsigned T_PH     = 8,
  parameter logic [7:0]  CMD_DATA = 8'h00
) (
  input logic            clk,
  input logic            reset,
  rtc_write_seq_if.slave io_bus
);

  rtc_state_e          r_state;
  logic                r_busy;
  logic                r_done;
  logic                r_ad_oe;
  logic [7:0]          r_ad_out;
  logic [IDX_W-1:0]    r_idx;
  logic [NUM_REGS-1:0] r_mask;

  logic             w_phase_start;
  logic             w_phase_sel;
  logic             w_phase_end;
  logic             w_cs;
  logic             w_wr;
  logic             w_a_d;
  logic [IDX_W-1:0] w_next_idx;
  logic [7:0]       w_dat;

  assign w_next_idx    = rtc_next_idx(r_mask, r_idx);
  assign w_dat         = (r_idx == '0) ? CMD_DATA : io_bus.reg_data;
  assign w_phase_sel   = (r_state == StAdrRel);
  assign w_phase_start = ((r_state == StIdle) && r_busy) ||
                         ((r_state == StAdrRel) && w_phase_end) ||
                         ((r_state == StNext) && (w_next_idx != '0));

  rtc_bus_phase #(
    .T_PH (T_PH)
  ) u_bus_phase (
    .clk           (clk),
    .reset         (reset),
    .i_phase_start (w_phase_start),
    .i_phase_sel   (w_phase_sel),
    .o_phase_end   (w_phase_end),
    .o_cs          (w_cs),
    .o_wr          (w_wr),
    .o_a_d         (w_a_d)
  );

  // IDLE with busy set is the one-cycle gap between the start edge and the first strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= StIdle;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_ad_oe  <= 1'b0;
      r_ad_out <= '0;
      r_idx    <= '0;
      r_mask   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (r_busy) begin
            r_state  <= StAdrStb;
            r_ad_oe  <= 1'b1;
            r_ad_out <= rtc_addr(r_idx);
          end else if (io_bus.start) begin
            r_busy <= 1'b1;
            r_idx  <= '0;
            r_mask <= io_bus.wr_mask;
          end
        end
        StAdrStb: if (w_phase_end) r_state <= StAdrRel;
        StAdrRel: begin
          if (w_phase_end) begin
            r_state  <= StDatStb;
            r_ad_out <= w_dat;
          end
        end
        StDatStb: if (w_phase_end) r_state <= StDatRel;
        StDatRel: if (w_phase_end) r_state <= StNext;
        StNext: begin
          if (w_next_idx != '0) begin
            r_state  <= StAdrStb;
            r_idx    <= w_next_idx;
            r_ad_out <= rtc_addr(w_next_idx);
          end else begin
            r_state  <= StDone;
            r_done   <= 1'b1;
            r_ad_oe  <= 1'b0;
            r_ad_out <= '0;
          end
        end
        StDone: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign io_bus.reg_idx = r_idx;
  assign io_bus.ad_out  = r_ad_out;
  assign io_bus.ad_oe   = r_ad_oe;
  assign io_bus.a_d     = w_a_d;
  assign io_bus.cs      = w_cs;
  assign io_bus.wr      = w_wr;
  assign io_bus.rd      = 1'b1;
  assign io_bus.busy    = r_busy;
  assign io_bus.done    = r_done;

endmodule
